// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline register with 2-entry skid; 1-cycle latency, 1 entry/cycle streaming.
// in_ready is registered (!skid_v): accepts one extra entry into skid once main stalls, then deasserts.
module pipeline_stage_elastic #(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 6,
  parameter int                REG_W    = 5,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_W-1:0]  out_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  rd;
  } entry_t;

  localparam entry_t IDLE_ENTRY = '{data: '0, ctrl: NOP_CTRL, rd: '0};

  logic       main_v;
  logic       skid_v;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     in_entry;
  logic       in_fire;
  logic       out_fire;
  logic [CNT_W-1:0] cnt_q;

  assign in_entry = '{data: in_data, ctrl: in_ctrl, rd: in_rd};
  assign in_fire  = in_valid & ~skid_v;
  assign out_fire = main_v & out_ready;

  // Main is refilled from skid first so ordering stays FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= IDLE_ENTRY;
      skid_q <= IDLE_ENTRY;
    end else if (!main_v || out_fire) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (in_fire) begin
        main_q <= in_entry;
        main_v <= 1'b1;
      end else begin
        main_q <= IDLE_ENTRY;
        main_v <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q <= in_entry;
      skid_v <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_q <= '0;
    end else if (main_v && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_q.data;
  assign out_ctrl  = main_q.ctrl;
  assign out_rd    = main_q.rd;
  assign stall_cnt = cnt_q;

endmodule

// File: doc/pipeline_stage_elastic.md
Name: pipeline_stage_elastic

Overview:
- Parametrised successor to the fixed EXE->MEM pipeline register.
- Generalises payload width and control width, and replaces the single stall input with a valid/ready elastic handshake.
- A 2-entry skid buffer lets upstream see a fully registered ready, with no combinational path from out_ready.
- Adds a flush that inserts a programmable NOP control pattern, plus a saturating back-pressure counter for performance debug. One instance sits between each pair of accelerator pipeline stages.

Parameters:
DATA_W, 96, payload width in bits (e.g. ALUResult, WriteData, PCPlus4 concatenated)
CTRL_W, 6, control bundle width (RegWrite, ResultSrc, WDME, isLoad, WD3Src, floatingWrite)
REG_W, 5, destination/source register index width, exported for hazard detection
NOP_CTRL, 0, control pattern presented whenever the stage holds no valid entry
CNT_W, 16, back-pressure counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard both entries this cycle
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry; registered, equals !skid_v
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bundle
in_rd  input  REG_W  upstream destination register
out_valid  output  1  main entry valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  main payload
out_ctrl  output  CTRL_W  main control; NOP_CTRL when !out_valid
out_rd  output  REG_W  main destination register; 0 when !out_valid
stall_cnt  output  CNT_W  cycles with out_valid & !out_ready, saturating
clr_cnt  input  1  synchronous clear of stall_cnt

Behaviour:
- State: main entry {main_v, data, ctrl, rd}; skid entry {skid_v, data, ctrl, rd}. Outputs are driven directly from the main registers.
- Invariant: skid_v implies main_v.
- Handshake signals: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. in_ready = !skid_v.
- Reset (rst=1 at an edge), regardless of any other input:
  - main_v = 0, skid_v = 0.
  - out_ctrl = NOP_CTRL, out_data = 0, out_rd = 0.
  - stall_cnt = 0.
  - in_ready reads 1 in the cycle after reset.
  - Reset mid-transfer drops both entries silently.
- Flush (rst=0, flush=1):
  - main_v = 0, skid_v = 0; main ctrl = NOP_CTRL, data = 0, rd = 0.
  - Any in_fire in that cycle is accepted and discarded.
  - Flush has priority over all transfers. stall_cnt is unaffected.
- Normal operation (rst=0, flush=0):
  - If !main_v or out_fire:
    - skid_v: main <= skid, skid_v <= 0.
    - else if in_fire: main <= input, main_v <= 1.
    - else: main_v <= 0, ctrl <= NOP_CTRL, data <= 0, rd <= 0.
  - Else (main held) and in_fire: skid <= input, skid_v <= 1.
  - In all other cases the registers hold.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is 1 entry/cycle while out_ready=1.
- Ordering is strictly FIFO. No entry is duplicated or lost except on flush or reset.
- Back-pressure: while out_ready=0 and main is full, the stage accepts exactly one more entry into skid, then in_ready=0.
- stall_cnt:
  - Increments by 1 on every cycle with out_valid & !out_ready.
  - Holds at 2^CNT_W-1 once saturated.
  - clr_cnt=1 forces 0; clr_cnt wins over increment.
- While !out_valid, out_ctrl, out_data and out_rd are exactly NOP_CTRL, 0 and 0, so hazard logic never sees stale values.

Test Plan:
- Streaming: reset, then in_valid=1 with data 1,2,3,4 and out_ready=1 -> out_data 1,2,3,4 on consecutive cycles starting 1 cycle after the first in_fire; in_ready stays 1.
- Back-pressure: out_ready=0, push A, B, C -> A in main, B in skid, in_ready=0 after B, C held upstream. Raise out_ready -> outputs A, B, C in order with no gap; stall_cnt equals the number of cycles out_valid=1 with out_ready=0.
- Flush: stage holding A (main) and B (skid), assert flush with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=NOP_CTRL, out_rd=0, in_ready=1; C never appears at the output.
- NOP pattern: NOP_CTRL=6'b000001, idle stage after reset -> out_ctrl=6'b000001, out_data=0, out_rd=0.
- Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15. Pulse clr_cnt during a stall -> stall_cnt=0 next cycle, then resumes counting.
- Reset mid-operation: both entries full, assert rst together with flush and in_valid -> all outputs at reset values, stall_cnt=0, in_ready=1 the following cycle.
